// File: rtl/accumulator_driver.sv
// Initiator for the accumulator load/ready interface: packs k samples, requests a load, returns the sum.
// Optional self-check of the returned sum against a local reference: define ACC_DRV_CHECK_EN.
module accumulator_driver #(
    parameter int m = 4,
    parameter int n = 4,
    parameter int k = 10,
    localparam int width = m + n,
    localparam int swidth = $clog2(k * (2 ** (m + n) - 1)),
    localparam int cwidth = $clog2(k)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [width-1:0]     s_data,
    output logic                 pl,
    output logic [k*width-1:0]   din,
    input  logic                 acc_ready,
    input  logic [swidth-1:0]    acc_sum,
    output logic                 sum_valid,
    input  logic                 sum_ready,
    output logic [swidth-1:0]    sum_out,
    output logic                 err
);

    localparam logic [1:0] FILL = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    logic [1:0]        state;
    logic [cwidth-1:0] idx;
    logic              accept;
    logic              last;
    logic              capture;

    assign s_ready = (state == FILL);
    assign accept  = s_ready && s_valid;
    assign last    = (idx == cwidth'(k - 1));
    assign capture = (state == WAIT) && acc_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= FILL;
            idx       <= '0;
            pl        <= 1'b0;
            din       <= '0;
            sum_valid <= 1'b0;
            sum_out   <= '0;
        end else begin
            unique case (state)
                FILL: begin
                    if (s_valid) begin
                        for (int j = 0; j < k; j++) begin
                            if (idx == cwidth'(j))
                                din[j*width +: width] <= s_data;
                        end
                        if (last) begin
                            idx   <= '0;
                            pl    <= 1'b1;
                            state <= LOAD;
                        end else begin
                            idx <= idx + cwidth'(1);
                        end
                    end
                end
                // acc_ready is not looked at here: it may still be high from the last round
                LOAD: state <= WAIT;
                WAIT: begin
                    if (acc_ready) begin
                        sum_out   <= acc_sum;
                        sum_valid <= 1'b1;
                        pl        <= 1'b0;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (sum_ready) begin
                        sum_valid <= 1'b0;
                        state     <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

`ifdef ACC_DRV_CHECK_EN
    logic [swidth-1:0] ref_sum;
    logic              err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ref_sum <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept)
                ref_sum <= (idx == '0 ? '0 : ref_sum) + swidth'(s_data);
            if (capture && (acc_sum != ref_sum))
                err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_accumulator_driver.sv
// Directed bench for accumulator_driver: fill, load, wait, output handshake and reset cases.
module tb_accumulator_driver;

    logic        clk = 1'b0;
    logic        rstn;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        pl;
    logic [79:0] din;
    logic        acc_ready;
    logic [11:0] acc_sum;
    logic        sum_valid;
    logic        sum_ready;
    logic [11:0] sum_out;
    logic        err;

    int checks = 0;
    int errors = 0;

`ifdef ACC_DRV_CHECK_EN
    localparam logic exp_err = 1'b1;
`else
    localparam logic exp_err = 1'b0;
`endif

    accumulator_driver dut (
        .clk(clk),
        .rstn(rstn),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data(s_data),
        .pl(pl),
        .din(din),
        .acc_ready(acc_ready),
        .acc_sum(acc_sum),
        .sum_valid(sum_valid),
        .sum_ready(sum_ready),
        .sum_out(sum_out),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [79:0] obs,
                         input logic [79:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        s_valid = 1'b1;
        s_data  = v;
        tick();
    endtask

    // ready raised after 'delay' idle cycles past LOAD; capture on the following edge
    task automatic finish_round(input logic [11:0] sum, input int delay);
        acc_ready = 1'b0;
        acc_sum   = sum;
        repeat (delay) tick();
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
    endtask

    initial begin
        rstn      = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        acc_ready = 1'b0;
        acc_sum   = '0;
        sum_ready = 1'b1;

        repeat (3) tick();
        rstn = 1'b1;
        check("rst_pl", {79'd0, pl}, 80'd0);
        check("rst_din", din, 80'd0);
        check("rst_sum_valid", {79'd0, sum_valid}, 80'd0);
        check("rst_sum_out", {68'd0, sum_out}, 80'd0);
        check("rst_err", {79'd0, err}, 80'd0);
        check("rst_s_ready", {79'd0, s_ready}, 80'd1);

        // round 1: samples 1..10, ready three cycles after pl
        for (int i = 1; i <= 9; i++) send(8'(i));
        check("r1_pl_before_last", {79'd0, pl}, 80'd0);
        send(8'd10);
        s_valid = 1'b0;
        check("r1_pl_rise", {79'd0, pl}, 80'd1);
        check("r1_din", din, 80'h0a_09_08_07_06_05_04_03_02_01);
        check("r1_s_ready_load", {79'd0, s_ready}, 80'd0);
        acc_ready = 1'b0;
        acc_sum   = 12'd55;
        tick();
        tick();
        check("r1_pl_hold", {79'd0, pl}, 80'd1);
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        check("r1_sum_valid", {79'd0, sum_valid}, 80'd1);
        check("r1_sum_out", {68'd0, sum_out}, 80'd55);
        check("r1_pl_drop", {79'd0, pl}, 80'd0);
        tick();
        check("r1_sum_valid_clr", {79'd0, sum_valid}, 80'd0);
        check("r1_back_to_fill", {79'd0, s_ready}, 80'd1);

        // round 2: ten 255s, acc_ready high throughout with a stale sum
        acc_ready = 1'b1;
        acc_sum   = 12'd77;
        for (int i = 0; i < 10; i++) send(8'hff);
        s_valid = 1'b0;
        check("r2_load_no_capture", {79'd0, sum_valid}, 80'd0);
        check("r2_din", din, {10{8'hff}});
        tick();
        check("r2_wait_no_capture", {79'd0, sum_valid}, 80'd0);
        check("r2_wait_pl", {79'd0, pl}, 80'd1);
        acc_sum = 12'd2550;
        tick();
        acc_ready = 1'b0;
        check("r2_first_wait_capture", {79'd0, sum_valid}, 80'd1);
        check("r2_sum_out", {68'd0, sum_out}, 80'd2550);

        // output stall with samples offered
        sum_ready = 1'b0;
        s_valid   = 1'b1;
        s_data    = 8'h09;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_sum_valid", {79'd0, sum_valid}, 80'd1);
            check("stall_sum_out", {68'd0, sum_out}, 80'd2550);
            check("stall_s_ready", {79'd0, s_ready}, 80'd0);
        end
        sum_ready = 1'b1;
        tick();
        check("stall_release", {79'd0, sum_valid}, 80'd0);
        check("stall_no_consume", din, {10{8'hff}});
        send(8'd20);
        check("r3_slot0", {72'd0, din[7:0]}, 80'h14);
        check("r3_slot1_kept", {72'd0, din[15:8]}, 80'hff);
        for (int i = 21; i <= 29; i++) send(8'(i));
        s_valid   = 1'b0;
        acc_ready = 1'b0;
        tick();

        // asynchronous reset during WAIT
        #2;
        rstn = 1'b0;
        #1;
        check("arst_pl", {79'd0, pl}, 80'd0);
        check("arst_sum_valid", {79'd0, sum_valid}, 80'd0);
        check("arst_din", din, 80'd0);
        check("arst_s_ready", {79'd0, s_ready}, 80'd1);
        tick();
        rstn = 1'b1;
        send(8'd1);
        check("arst_idx0", din, 80'h01);

        // wrong sum returned, then a correct round
        for (int i = 2; i <= 10; i++) send(8'(i));
        s_valid = 1'b0;
        finish_round(12'd54, 1);
        check("bad_sum_out", {68'd0, sum_out}, 80'd54);
        check("bad_err", {79'd0, err}, {79'd0, exp_err});
        tick();
        for (int i = 1; i <= 10; i++) send(8'(i));
        s_valid = 1'b0;
        finish_round(12'd55, 1);
        check("good_sum_out", {68'd0, sum_out}, 80'd55);
        check("err_sticky", {79'd0, err}, {79'd0, exp_err});
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/accumulator_driver.md
Name: accumulator_driver

Overview:
Initiator side of the accumulator load/ready interface. Collects k serial samples of width m+n over a valid/ready stream and packs them into the k*width `din` bus. It then asserts `pl` and holds it until the accumulator raises `ready`. It captures the returned sum and presents it on a valid/ready output handshake. It sits between a sample producer and the accumulator.

Parameters:
m, 4, upper operand field width; sample width = m+n
n, 4, lower operand field width
k, 10, samples per accumulation (k >= 2)
width (localparam), m+n, sample width
swidth (localparam), $clog2(k*(2**(m+n)-1)), sum width; must match the accumulator
cwidth (localparam), $clog2(k), slot index width

Ports:
clk  in  1  clock, all logic on the rising edge
rstn  in  1  asynchronous, active-low reset
s_valid  in  1  sample valid
s_ready  out  1  sample accepted when s_valid && s_ready
s_data  in  width  sample value
pl  out  1  parallel-load request to the accumulator
din  out  k*width  packed samples; slot j = din[j*width +: width]
acc_ready  in  1  accumulator done
acc_sum  in  swidth  accumulator result
sum_valid  out  1  result valid
sum_ready  in  1  result consumer ready
sum_out  out  swidth  captured result
err  out  1  sticky self-check error; 0 unless ACC_DRV_CHECK_EN is defined

Behaviour:
- Reset (asynchronous, rstn=0): state=FILL, idx=0, pl=0, din=0, sum_valid=0, sum_out=0, err=0. s_ready=1 once in FILL.
- FSM states FILL, LOAD, WAIT, OUT.
- FILL: s_ready=1.
  - Each accepted sample is written to slot idx; idx increments.
  - On the accept with idx==k-1: idx->0, next state LOAD.
  - Slots not yet written in this round keep their previous values.
- LOAD: exactly one cycle. pl=1, s_ready=0. acc_ready is ignored here so a stale ready from the prior operation is never captured. Next state WAIT.
- WAIT: pl=1, s_ready=0, din frozen.
  - On the first cycle with acc_ready=1: sum_out<=acc_sum, sum_valid<=1, pl<=0, next state OUT.
  - No timeout; WAIT holds indefinitely.
- OUT: pl=0, s_ready=0, sum_valid=1, sum_out stable.
  - On sum_ready=1: sum_valid<=0, next state FILL.
  - This guarantees pl is low for at least one cycle between operations.
- Latency:
  - pl rises on the edge that accepts the k-th sample.
  - sum_valid rises on the edge after acc_ready is sampled high in WAIT.
  - Minimum round length is k + 3 cycles when the consumer is always ready.
- din changes only in FILL. It is stable from pl rising until the next FILL accept.
- Simultaneous events:
  - s_valid is ignored outside FILL.
  - acc_ready outside WAIT is ignored.
  - sum_ready outside OUT is ignored.
- Reset mid-operation returns to FILL immediately, with pl=0 asynchronously. A partial round is discarded.

Optional Feature:
Macro ACC_DRV_CHECK_EN.
- Defined:
  - A reference sum register, swidth bits, clears at the start of each round.
  - Each accepted sample is added to it, zero-extended, modulo 2^swidth.
  - On capture in WAIT, if acc_sum != reference, err<=1.
  - err is sticky until reset.
- Not defined: no reference logic is built, and err is tied to 0.

Test Plan:
- Reset: hold rstn=0 three cycles, then release -> pl=0, din=0, sum_valid=0, sum_out=0, err=0, s_ready=1.
- Samples 1..10 back-to-back, model ready 3 cycles after pl -> din slot0=1 … slot9=10. pl rises the cycle after the 10th accept and stays high until ready. sum_out=55, sum_valid=1.
- Ten samples of 255 -> sum_out=2550, with no truncation at swidth=12.
- acc_ready held high continuously from the prior round -> no capture in LOAD. Capture occurs in the first WAIT cycle, and sum_out equals the new round's acc_sum.
- sum_ready low for 5 cycles in OUT, s_valid=1 throughout -> sum_valid and sum_out stable, s_ready=0, no samples consumed. After sum_ready=1, the next round fills from slot 0.
- rstn pulsed low during WAIT -> pl drops without waiting for a clock, idx=0, sum_valid=0. With ACC_DRV_CHECK_EN defined and a model returning 54 instead of 55 -> err=1, and it stays 1 through later correct rounds.
